// File: rtl/y86_fetch_unit.sv
// -----------------------------------------------------------------------------
// y86_fetch_unit
//
// Multi-cycle Y86-32 fetch stage. It reads one byte per memory handshake at
// the current PC, assembles 1/2/5/6-byte instructions and hands the decoded
// fields to the decode stage.
//
// Handshakes:
//   Memory side: once mem_req rises it stays high with mem_addr stable until
//   a cycle with mem_req && mem_ack. The byte on mem_rdata is captured on that
//   edge. mem_ack may be high in the same cycle mem_req rises.
//   Downstream side: ins_valid stays high with every field stable until a
//   cycle with ins_valid && ins_ready; the instruction is consumed on that
//   edge. A pc_load in that same cycle wins and the instruction is dropped.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   pc_load, pc_new     PC redirect strobe and target (highest priority)
//   mem_req, mem_addr   byte read request / address (pc + byte index)
//   mem_rdata, mem_ack  returned byte / byte valid
//   ins_valid, ins_ready  downstream handshake
//   icode, ifun, rA, rB decoded fields (rA/rB read 4'hF when absent)
//   valC, valP, pc_out  little-endian constant, next sequential PC, this PC
//   instr_err           icode C..F presented with ins_valid
//   imem_error          memory timeout (sticky until reset or pc_load)
//   fsm_state           current FSM state, for debug and checkers
//
// Build option:
//   FETCH_TIMEOUT_EN    when defined, a request left unacknowledged for
//                       TIMEOUT_CYC cycles raises imem_error, drops mem_req
//                       and parks the unit in HALT. When undefined the unit
//                       waits indefinitely and imem_error stays 0.
// -----------------------------------------------------------------------------
module y86_fetch_unit #(
    parameter int                     DATA_WID    = 32,
    parameter int                     ADDR_WID    = 4,
    parameter logic [DATA_WID-1:0]    RESET_PC    = '0,
    parameter int                     TIMEOUT_CYC = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                pc_load,
    input  logic [DATA_WID-1:0] pc_new,
    output logic                mem_req,
    output logic [DATA_WID-1:0] mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [ADDR_WID-1:0] icode,
    output logic [ADDR_WID-1:0] ifun,
    output logic [ADDR_WID-1:0] rA,
    output logic [ADDR_WID-1:0] rB,
    output logic [DATA_WID-1:0] valC,
    output logic [DATA_WID-1:0] valP,
    output logic [DATA_WID-1:0] pc_out,
    output logic                instr_err,
    output logic                imem_error,
    output logic [2:0]          fsm_state
);

    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        FETCH_REG = 3'd1,
        FETCH_C   = 3'd2,
        HOLD      = 3'd3,
        HALT      = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_WID-1:0] pc;
    logic [1:0]          cnt;      // valC byte index inside FETCH_C
    logic                flush;    // drop the byte of a request orphaned by pc_load
    logic                take;     // a byte is delivered this cycle
    logic                tmo_fire;
    logic [3:0]          byte_hi;
    logic [3:0]          byte_lo;

    assign take      = mem_req && mem_ack;
    assign byte_hi   = mem_rdata[7:4];
    assign byte_lo   = mem_rdata[3:0];
    assign fsm_state = state;

    // Instruction length in bytes; invalid codes C..F count as one byte.
    function automatic logic [2:0] ins_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: ins_len = 3'd2;
            4'h7, 4'h8:             ins_len = 3'd5;
            4'h3, 4'h4, 4'h5:       ins_len = 3'd6;
            default:                ins_len = 3'd1;
        endcase
    endfunction

    function automatic logic has_reg(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:                                  has_reg = 1'b0;
        endcase
    endfunction

    function automatic logic has_c(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_c = 1'b1;
            default:                      has_c = 1'b0;
        endcase
    endfunction

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts consecutive cycles of an unanswered request. Cleared when it
    // fires so a request kept alive by a simultaneous pc_load starts afresh.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (mem_req && !mem_ack && !tmo_fire) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_fire = mem_req && !mem_ack && (tmo_cnt >= TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= FETCH_OP;
            pc         <= RESET_PC;
            cnt        <= 2'd0;
            flush      <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ins_valid  <= 1'b0;
            icode      <= '0;
            ifun       <= '0;
            rA         <= '0;
            rB         <= '0;
            valC       <= '0;
            valP       <= '0;
            pc_out     <= '0;
            instr_err  <= 1'b0;
            imem_error <= 1'b0;
        end else if (pc_load) begin
            pc         <= pc_new;
            state      <= FETCH_OP;
            cnt        <= 2'd0;
            ins_valid  <= 1'b0;
            instr_err  <= 1'b0;
            imem_error <= 1'b0;
            if (mem_req && !mem_ack) begin
                // The memory still owes a byte: keep the request alive on the
                // old address and throw the byte away when it arrives.
                flush <= 1'b1;
            end else begin
                flush    <= 1'b0;
                mem_req  <= 1'b1;
                mem_addr <= pc_new;
            end
        end else if (tmo_fire) begin
            imem_error <= 1'b1;
            mem_req    <= 1'b0;
            flush      <= 1'b0;
            state      <= HALT;
        end else if (flush) begin
            if (take) begin
                flush    <= 1'b0;
                mem_addr <= pc;
            end
        end else begin
            case (state)
                FETCH_OP: begin
                    if (!mem_req) begin
                        // First cycle after reset: open the request.
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end else if (take) begin
                        icode     <= byte_hi;
                        ifun      <= byte_lo;
                        rA        <= '1;
                        rB        <= '1;
                        valC      <= '0;
                        pc_out    <= pc;
                        valP      <= pc + DATA_WID'(ins_len(byte_hi));
                        instr_err <= (byte_hi >= 4'hC);
                        if (has_reg(byte_hi)) begin
                            state    <= FETCH_REG;
                            mem_addr <= mem_addr + 1'b1;
                        end else if (has_c(byte_hi)) begin
                            state    <= FETCH_C;
                            cnt      <= 2'd0;
                            mem_addr <= mem_addr + 1'b1;
                        end else begin
                            state     <= HOLD;
                            mem_req   <= 1'b0;
                            ins_valid <= 1'b1;
                        end
                    end
                end

                FETCH_REG: begin
                    if (take) begin
                        rA <= byte_hi;
                        rB <= byte_lo;
                        if (has_c(icode)) begin
                            state    <= FETCH_C;
                            cnt      <= 2'd0;
                            mem_addr <= mem_addr + 1'b1;
                        end else begin
                            state     <= HOLD;
                            mem_req   <= 1'b0;
                            ins_valid <= 1'b1;
                        end
                    end
                end

                FETCH_C: begin
                    if (take) begin
                        valC[{cnt, 3'b000} +: 8] <= mem_rdata;
                        cnt <= cnt + 2'd1;   // wraps 3 -> 0 on the last byte
                        if (cnt == 2'd3) begin
                            state     <= HOLD;
                            mem_req   <= 1'b0;
                            ins_valid <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (ins_ready) begin
                        ins_valid <= 1'b0;
                        pc        <= valP;
                        if (icode == 4'h0 || instr_err) begin
                            state <= HALT;
                        end else begin
                            state    <= FETCH_OP;
                            mem_req  <= 1'b1;
                            mem_addr <= valP;
                        end
                    end
                end

                HALT: begin
                    // Idle until a redirect.
                end

                default: begin
                    state   <= HALT;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// -----------------------------------------------------------------------------
// Bench for y86_fetch_unit: byte memory model with programmable ack latency,
// expected-instruction queue popped at each accepted instruction, directed
// checks for latency, stall stability, redirect/flush, halt and timeout.
// -----------------------------------------------------------------------------
module tb_y86_fetch_unit;

    localparam int EXP_W = 4 * 4 + 32 * 3 + 1;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] valc;
        logic [31:0] valp;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        ins_valid;
    logic        ins_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [31:0] valC;
    logic [31:0] valP;
    logic [31:0] pc_out;
    logic        instr_err;
    logic        imem_error;
    logic [2:0]  fsm_state;

    logic [EXP_W-1:0] exp_q[$];
    int tests;
    int fails;

    // Memory model
    logic [7:0] mem [0:1023];
    int         mem_lat;
    int         lat_cnt;
    logic       mem_en;

    y86_fetch_unit #(
        .DATA_WID(32),
        .ADDR_WID(4),
        .RESET_PC(32'h0),
        .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .pc_load(pc_load),
        .pc_new(pc_new),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .icode(icode),
        .ifun(ifun),
        .rA(rA),
        .rB(rB),
        .valC(valC),
        .valP(valP),
        .pc_out(pc_out),
        .instr_err(instr_err),
        .imem_error(imem_error),
        .fsm_state(fsm_state)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign mem_ack   = mem_en && mem_req && (lat_cnt >= mem_lat);
    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge CLK) begin
        if (mem_req && !mem_ack) lat_cnt <= lat_cnt + 1;
        else                     lat_cnt <= 0;
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic push_exp(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [31:0] vc, input logic [31:0] vp,
                            input logic [31:0] pc, input logic err);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.pc = pc; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic pulse_load(input logic [31:0] target);
        pc_new  = target;
        pc_load = 1'b1;
        @(negedge CLK);
        pc_load = 1'b0;
    endtask

    // Waits for the request to open, then counts cycles until ins_valid.
    task automatic fetch_latency(output int lat, output logic [31:0] addr0);
        int guard;
        guard = 0;
        lat   = 0;
        while (!mem_req && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        addr0 = mem_addr;
        while (!ins_valid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        if (!ins_valid) check("valid_timeout", 32'(ins_valid), 32'd1);
    endtask

    // Scoreboard pop: compare presented fields, then accept for one cycle.
    task automatic accept_ins();
        exp_t e;
        check("accept_valid", 32'(ins_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("icode",     32'(icode),     32'(e.icode));
            check("ifun",      32'(ifun),      32'(e.ifun));
            check("rA",        32'(rA),        32'(e.ra));
            check("rB",        32'(rB),        32'(e.rb));
            check("valC",      valC,           e.valc);
            check("valP",      valP,           e.valp);
            check("pc_out",    pc_out,         e.pc);
            check("instr_err", 32'(instr_err), 32'(e.err));
        end
        ins_ready = 1'b1;
        @(negedge CLK);
        ins_ready = 1'b0;
    endtask

    task automatic check_halted(input string tag);
        repeat (3) @(negedge CLK);
        check({tag, "_mem_req"}, 32'(mem_req),   32'd0);
        check({tag, "_state"},   32'(fsm_state), 32'd4);
        check({tag, "_valid"},   32'(ins_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        int          guard;
        logic [31:0] a0;

        tests     = 0;
        fails     = 0;
        RST_N     = 1'b0;
        pc_load   = 1'b0;
        pc_new    = '0;
        ins_ready = 1'b0;
        mem_en    = 1'b1;
        mem_lat   = 0;
        lat_cnt   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]     = 8'h10;                                   // nop
        mem[1]     = 8'h00;                                   // halt
        mem[10'h100] = 8'h30; mem[10'h101] = 8'hF2;           // irmovl
        mem[10'h102] = 8'h78; mem[10'h103] = 8'h56;
        mem[10'h104] = 8'h34; mem[10'h105] = 8'h12;
        mem[10'h106] = 8'h60; mem[10'h107] = 8'h12;           // addl
        mem[10'h108] = 8'h70; mem[10'h109] = 8'h00;           // jmp (aborted)
        mem[10'h10A] = 8'h02; mem[10'h10B] = 8'h00; mem[10'h10C] = 8'h00;
        mem[10'h040] = 8'hC0;                                 // invalid
        mem[10'h200] = 8'h10;                                 // must be dropped
        mem[10'h300] = 8'h20; mem[10'h301] = 8'h34;           // rrmovl (discarded)
        mem[10'h310] = 8'h10;                                 // nop

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_mem_req",    32'(mem_req),    32'd0);
        check("rst_ins_valid",  32'(ins_valid),  32'd0);
        check("rst_instr_err",  32'(instr_err),  32'd0);
        check("rst_imem_error", 32'(imem_error), 32'd0);
        check("rst_icode",      32'(icode),      32'd0);
        check("rst_valP",       valP,            32'd0);
        check("rst_pc_out",     pc_out,          32'd0);
        check("rst_state",      32'(fsm_state),  32'd0);
        RST_N = 1'b1;

        // nop at 0, zero-wait memory
        push_exp(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 32'h0, 1'b0);
        fetch_latency(lat, a0);
        check("nop_addr", a0, 32'h0);
        check("nop_lat", lat, 32'd1);
        accept_ins();

        // halt at 1 -> HALT with instr_err = 0
        push_exp(4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h2, 32'h1, 1'b0);
        fetch_latency(lat, a0);
        check("halt_addr", a0, 32'h1);
        check("halt_lat", lat, 32'd1);
        accept_ins();
        check_halted("halt");

        // irmovl at 0x100
        pulse_load(32'h100);
        push_exp(4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678, 32'h106, 32'h100, 1'b0);
        fetch_latency(lat, a0);
        check("irmovl_addr", a0, 32'h100);
        check("irmovl_lat", lat, 32'd6);
        accept_ins();

        // addl at 0x106, stalled for 5 cycles
        push_exp(4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h108, 32'h106, 1'b0);
        fetch_latency(lat, a0);
        check("opl_lat", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("stall_mem_req", 32'(mem_req),   32'd0);
            check("stall_valid",   32'(ins_valid), 32'd1);
            check("stall_icode",   32'(icode),     32'h6);
            check("stall_rB",      32'(rB),        32'h2);
            check("stall_valP",    valP,           32'h108);
            @(negedge CLK);
        end
        mem_lat = 3;
        accept_ins();
        check("next_req",  32'(mem_req), 32'd1);
        check("next_addr", mem_addr,     32'h108);

        // jmp with 3-cycle memory, redirected in the middle of its constant
        guard = 0;
        while (!(fsm_state == 3'd2 && mem_addr == 32'h10A) && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check("abort_point", 32'(mem_addr), 32'h10A);
        check("abort_pending", 32'(mem_ack), 32'd0);
        pulse_load(32'h40);
        check("flush_req",   32'(mem_req),   32'd1);
        check("flush_addr",  mem_addr,       32'h10A);
        check("flush_valid", 32'(ins_valid), 32'd0);
        guard = 0;
        while (mem_addr == 32'h10A && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check("redirect_addr",  mem_addr,       32'h40);
        check("redirect_valid", 32'(ins_valid), 32'd0);

        // invalid icode at 0x40
        push_exp(4'hC, 4'h0, 4'hF, 4'hF, 32'h0, 32'h41, 32'h40, 1'b1);
        fetch_latency(lat, a0);
        check("inv_addr", a0, 32'h40);
        check("inv_lat", lat, 32'd4);
        accept_ins();
        check_halted("inv");

        // Memory never answers
        mem_en  = 1'b0;
        mem_lat = 0;
        pulse_load(32'h200);
        guard = 0;
        while (mem_req && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
`ifdef FETCH_TIMEOUT_EN
        check("tmo_cycles",     guard,           32'd16);
        check("tmo_imem_error", 32'(imem_error), 32'd1);
        check("tmo_state",      32'(fsm_state),  32'd4);
`else
        check("wait_cycles",     guard,           32'd40);
        check("wait_mem_req",    32'(mem_req),    32'd1);
        check("wait_imem_error", 32'(imem_error), 32'd0);
`endif

        // Redirect while the request may still be pending; memory comes back
        // one cycle later and the stale byte must not be decoded.
        pulse_load(32'h300);
        mem_en = 1'b1;
        check("clr_imem_error", 32'(imem_error), 32'd0);
        fetch_latency(lat, a0);
        check("rr_icode", 32'(icode), 32'h2);
        check("rr_rA",    32'(rA),    32'h3);
        check("rr_rB",    32'(rB),    32'h4);
        check("rr_valP",  valP,       32'h302);

        // Redirect with ins_ready high: the held rrmovl is discarded
        pc_new    = 32'h310;
        pc_load   = 1'b1;
        ins_ready = 1'b1;
        @(negedge CLK);
        pc_load   = 1'b0;
        ins_ready = 1'b0;
        check("discard_valid", 32'(ins_valid), 32'd0);
        push_exp(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h311, 32'h310, 1'b0);
        fetch_latency(lat, a0);
        check("after_discard_addr", a0, 32'h310);
        check("after_discard_lat", lat, 32'd1);
        accept_ins();

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/y86_fetch_unit.md
Name: y86_fetch_unit

Overview:
- Multi-cycle Y86-32 fetch stage between a byte-wide instruction memory and the decode/register-file stage.
- Fetches one byte per memory handshake at the current PC and assembles variable-length instructions (1, 2, 5 or 6 bytes).
- Presents icode/ifun/rA/rB/valC/valP to the downstream stage over a valid/ready handshake.
- Accepts PC redirects from the PC-select logic.

Parameters:
- DATA_WID, 32, PC / valC / valP width.
- ADDR_WID, 4, width of icode, ifun, rA, rB.
- RESET_PC, 32'h0, PC loaded on reset.
- TIMEOUT_CYC, 16, cycles without mem_ack before imem_error; used only with FETCH_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- pc_load  in  1  redirect strobe.
- pc_new  in  DATA_WID  redirect target.
- mem_req  out  1  byte read request.
- mem_addr  out  DATA_WID  byte address.
- mem_rdata  in  8  returned byte.
- mem_ack  in  1  mem_rdata valid; may assert in the same cycle as mem_req.
- ins_valid  out  1  instruction fields valid.
- ins_ready  in  1  downstream accepts.
- icode, ifun, rA, rB  out  ADDR_WID each  decoded fields.
- valC  out  DATA_WID  little-endian constant.
- valP  out  DATA_WID  PC of the next sequential instruction.
- pc_out  out  DATA_WID  PC of the presented instruction.
- instr_err  out  1  invalid icode.
- imem_error  out  1  memory timeout.

Behaviour:
- Reset (RST_N low, async):
  - State = FETCH_OP, pc = RESET_PC.
  - mem_req, ins_valid, instr_err and imem_error = 0.
  - icode/ifun/rA/rB/valC/valP/pc_out = 0.
  - Byte counter = 0, flush flag = 0.
- Memory handshake:
  - Once raised, mem_req stays high with mem_addr stable until a cycle with mem_req && mem_ack.
  - The byte is captured on that edge.
  - mem_addr = pc + byte index, modulo 2^DATA_WID.
  - mem_req = 0 in states HOLD and HALT.
- Instruction lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovl/cmovXX, 6 OPl, A pushl, B popl: 2 bytes.
  - 7 jXX, 8 call: 5 bytes.
  - 3 irmovl, 4 rmmovl, 5 mrmovl: 6 bytes.
  - C-F: invalid, length 1.
- FSM states:
  - FETCH_OP: byte0 yields icode = [7:4], ifun = [3:0]. Go to FETCH_REG, FETCH_C or HOLD according to the instruction format.
  - FETCH_REG: byte yields rA = [7:4], rB = [3:0]. Then FETCH_C for 6-byte instructions, else HOLD.
  - FETCH_C: 4 bytes, byte k placed at valC[8k+7:8k]. The 2-bit counter wraps 3 -> 0 on exit to HOLD.
  - HOLD: ins_valid = 1. All outputs are held stable until ins_ready.
    - On the accept edge: pc <= valP, ins_valid <= 0.
    - Next state is HALT if icode == 0 or instr_err, else FETCH_OP.
  - HALT: idle until pc_load.
- Field defaults:
  - Fields absent from the format read as rA = rB = 4'hF and valC = 0.
  - valP = pc + length, wrap-around modulo 2^DATA_WID.
  - pc_out = pc at byte0.
- Invalid icode:
  - instr_err = 1 alongside ins_valid; icode/ifun are passed as fetched.
- Redirect:
  - pc_load takes priority over every other event, in any state.
  - Next edge: pc <= pc_new, state <= FETCH_OP, counter cleared, ins_valid <= 0, instr_err <= 0.
  - An instruction in HOLD is discarded even if ins_ready is high in the same cycle.
  - If a request is outstanding (mem_req high, no ack yet), mem_req stays high on the old address and flush = 1. The returned byte is dropped, then fetching restarts at pc_new.
  - A pc_load in the same cycle as an ack: that byte is dropped.
- Latency:
  - With zero-wait memory (ack in the same cycle as req), an N-byte instruction raises ins_valid N cycles after fetch start.
  - The next fetch starts the cycle after acceptance; fetch and output do not overlap.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - A counter runs while mem_req && !mem_ack and resets on ack.
  - When it reaches TIMEOUT_CYC: imem_error <= 1 (sticky), mem_req <= 0, state <= HALT.
  - Only reset or pc_load clears imem_error.
- Disabled:
  - imem_error is tied to 0, the counter is absent, and the unit waits indefinitely for mem_ack.

Test Plan:
- Reset, zero-wait memory, byte 0x10 at address 0 -> icode = 1, ifun = 0, rA = rB = F, valC = 0, valP = 1, pc_out = 0; ins_valid in cycle 1.
- irmovl bytes 30 F2 78 56 34 12 at PC 0x100 -> rA = F, rB = 2, valC = 0x12345678, valP = 0x106; ins_valid 6 cycles after fetch start.
- ins_ready low for 5 cycles with OPl 60 12 presented -> outputs stable, no mem_req. Acceptance edge -> next mem_addr = pc + 2.
- Memory 3-cycle ack latency; pc_load = 1, pc_new = 0x40 issued mid-FETCH_C of a jXX -> outstanding byte discarded, next mem_addr = 0x40, no ins_valid for the aborted jXX.
- Byte 0xC0 -> ins_valid with instr_err = 1, valP = pc + 1. After acceptance the unit stays in HALT with mem_req = 0 until pc_load. halt (0x00) gives the same HALT behaviour with instr_err = 0.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYC = 16, mem_ack never asserted -> imem_error = 1 after 16 cycles of request, mem_req = 0. Without the macro -> mem_req held high, imem_error = 0.
